// File: rtl/xd_pkg.sv
// xd_pkg
// Shared types and defaults for the toggle-handshake (two-phase req/ack)
// clock-domain crossing blocks.
//   xd_rx_state_t       : receiver FSM state (IDLE waiting for a request,
//                         HOLD presenting a captured word downstream)
//   XD_SYNC_STAGES_DEF  : default synchroniser depth for req/ack paths
package xd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } xd_rx_state_t;

    localparam int XD_SYNC_STAGES_DEF = 2;

endpackage : xd_pkg

// File: rtl/xd_sync.sv
// xd_sync
// Single-bit multi-flop synchroniser for a level/toggle signal arriving from
// another clock domain. Also intended for the ack path of the matching
// transmitter.
// Ports:
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, all stages clear to 0
//   d_i     : asynchronous input bit
//   q_o     : synchronised output (last stage of the chain)
// Parameters:
//   STAGES  : number of flops in the chain, legal range 2..4
module xd_sync
    import xd_pkg::*;
#(
    parameter int STAGES = XD_SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    // The attribute keeps placement tight and stops retiming across the chain.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain; stage 0 is the only
    // flop allowed to go metastable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : xd_sync

// File: rtl/xd_hs_rx.sv
// xd_hs_rx
// Destination end of a two-phase bundled-data crossing. A request toggle on
// req_i is synchronised; the bundled data_i is then captured and offered on a
// valid/ready interface. Once consumed, ack_o is toggled back to the source.
// Ports:
//   clk_i, rst_ni  : destination clock, asynchronous active-low reset
//   req_i          : request toggle from the source domain
//   data_i         : bundled data, stable around each req_i toggle
//   ack_o          : acknowledge toggle back to the source (registered)
//   valid_o/data_o : captured word and its valid flag
//   ready_i        : downstream accepts data_o
//   busy_o         : request pending or word held
//   overrun_o      : sticky flag, source toggled again before ack
//   clr_i          : synchronous clear of overrun_o and xfer_cnt_o
//   xfer_cnt_o     : completed-transfer count, wraps
module xd_hs_rx
    import xd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = XD_SYNC_STAGES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  xfer_cnt_o
);

    xd_rx_state_t      state_q;
    logic              reqSync;
    logic              reqSync_q;
    logic              ack_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              overrun_q;
    logic [CNT_W-1:0]  xferCnt_q;

    logic              pend;
    logic              complete;
    logic              overrunEvt;

    xd_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reqSync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (req_i),
        .q_o    (reqSync)
    );

    // A request is outstanding whenever the synchronised req and our ack
    // disagree. An edge on reqSync seen while a word is still held means the
    // source did not wait for the ack.
    assign pend       = reqSync ^ ack_q;
    assign complete   = (state_q == HOLD) && valid_q && ready_i;
    assign overrunEvt = (state_q == HOLD) && (reqSync != reqSync_q);

    // Receiver FSM with all outputs registered. data_i is sampled only once
    // the toggle has crossed the synchroniser, by which time the bundled
    // data has been stable for SYNC_STAGES cycles. Overrun set takes
    // precedence over clr_i; clr_i takes precedence over the count increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            reqSync_q <= 1'b0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            xferCnt_q <= '0;
        end else begin
            reqSync_q <= reqSync;

            case (state_q)
                IDLE: begin
                    if (pend) begin
                        data_q  <= data_i;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (complete) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (overrunEvt) begin
                overrun_q <= 1'b1;
            end else if (clr_i) begin
                overrun_q <= 1'b0;
            end

            if (clr_i) begin
                xferCnt_q <= '0;
            end else if (complete) begin
                xferCnt_q <= xferCnt_q + 1'b1;
            end
        end
    end

    assign ack_o      = ack_q;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign overrun_o  = overrun_q;
    assign xfer_cnt_o = xferCnt_q;
    assign busy_o     = pend | valid_q;

endmodule : xd_hs_rx

// File: tb/tb_xd_hs_rx.sv
// tb_xd_hs_rx
// Self-checking bench for xd_hs_rx. Words are pushed to a scoreboard queue
// when the source toggles req_i and popped when a valid/ready handshake is
// observed. The DUT uses a 4-bit counter so the wrap can be exercised.
module tb_xd_hs_rx;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              req_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
    logic              busy_o;
    logic              overrun_o;
    logic              clr_i;
    logic [CNT_W-1:0]  xfer_cnt_o;

    int                testsRun    = 0;
    int                testsFailed = 0;
    logic [DATA_W-1:0] expQ[$];
    int                stableErrs;

    xd_hs_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .clr_i      (clr_i),
        .xfer_cnt_o (xfer_cnt_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Source side: set up data, then toggle req one cycle later.
    task automatic applyStimulus(input logic [DATA_W-1:0] d);
        data_i = d;
        waitCycles(1);
        req_i = ~req_i;
        expQ.push_back(d);
    endtask

    task automatic waitForValid();
        int n = 0;
        while (!valid_o && n < 20) begin
            waitCycles(1);
            n++;
        end
        checkOutput("valid_seen", valid_o, 1);
    endtask

    // Full source transaction: toggle req, then wait for the ack toggle.
    task automatic sendAndWait(input logic [DATA_W-1:0] d);
        logic prevAck;
        int   n = 0;
        prevAck = ack_o;
        applyStimulus(d);
        while (ack_o == prevAck && n < 30) begin
            waitCycles(1);
            n++;
        end
        if (ack_o == prevAck) checkOutput("ack_timeout", ack_o, ~prevAck);
    endtask

    // Scoreboard monitor: a handshake seen mid-cycle completes on the next
    // rising edge, so the word on data_o must be the oldest expected one.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", 1, 0);
            end else begin
                checkOutput("sb_data", data_o, expQ.pop_front());
            end
        end
    end

    initial begin
        rst_ni  = 1'b0;
        req_i   = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        clr_i   = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_ack", ack_o, 0);
        checkOutput("rst_data", data_o, 0);
        checkOutput("rst_cnt", xfer_cnt_o, 0);
        checkOutput("rst_ovr", overrun_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        waitCycles(2);

        // Single transfer with ready already high: exact latency and 1-cycle valid
        ready_i = 1'b1;
        data_i  = 8'hA5;
        waitCycles(1);
        req_i = 1'b1;
        expQ.push_back(8'hA5);
        waitCycles(2);
        checkOutput("lat_early", valid_o, 0);
        checkOutput("busy_pend", busy_o, 1);
        waitCycles(1);
        checkOutput("lat_valid", valid_o, 1);
        checkOutput("t1_data", data_o, 8'hA5);
        waitCycles(1);
        checkOutput("t1_valid_drop", valid_o, 0);
        checkOutput("t1_ack", ack_o, 1);
        checkOutput("t1_cnt", xfer_cnt_o, 1);
        checkOutput("t1_data_kept", data_o, 8'hA5);

        // Backpressure for 20 cycles
        ready_i = 1'b0;
        applyStimulus(8'h3C);
        waitForValid();
        checkOutput("bp_busy", busy_o, 1);
        stableErrs = 0;
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            if (valid_o !== 1'b1 || data_o !== 8'h3C || ack_o !== 1'b1) stableErrs++;
        end
        checkOutput("bp_stable", stableErrs, 0);
        ready_i = 1'b1;
        waitCycles(1);
        checkOutput("bp_ack", ack_o, 0);
        checkOutput("bp_valid_drop", valid_o, 0);
        checkOutput("bp_cnt", xfer_cnt_o, 2);

        // Four back-to-back transfers after a counter clear
        clr_i = 1'b1;
        waitCycles(1);
        clr_i = 1'b0;
        checkOutput("clr_cnt", xfer_cnt_o, 0);
        for (int i = 1; i <= 4; i++) sendAndWait(DATA_W'(i));
        waitCycles(2);
        checkOutput("b2b_ack", ack_o, 0);
        checkOutput("b2b_cnt", xfer_cnt_o, 4);
        checkOutput("b2b_ovr", overrun_o, 0);

        // Overrun: two extra req toggles while the word is held
        ready_i = 1'b0;
        applyStimulus(8'h55);
        waitForValid();
        checkOutput("ovr_pre", overrun_o, 0);
        req_i = ~req_i;
        waitCycles(4);
        checkOutput("ovr_set", overrun_o, 1);
        req_i = ~req_i;
        waitCycles(4);
        checkOutput("ovr_data", data_o, 8'h55);
        checkOutput("ovr_valid", valid_o, 1);
        ready_i = 1'b1;
        waitCycles(1);
        checkOutput("ovr_ack", ack_o, 1);
        waitCycles(8);
        checkOutput("ovr_no_extra", valid_o, 0);
        checkOutput("ovr_busy", busy_o, 0);
        checkOutput("ovr_cnt", xfer_cnt_o, 5);
        checkOutput("ovr_sticky", overrun_o, 1);
        clr_i = 1'b1;
        waitCycles(1);
        clr_i = 1'b0;
        checkOutput("ovr_clr", overrun_o, 0);
        checkOutput("ovr_clr_cnt", xfer_cnt_o, 0);

        // Reset asserted between edges while a word is held
        ready_i = 1'b0;
        applyStimulus(8'h77);
        waitForValid();
        #2;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        #1;
        checkOutput("mr_valid", valid_o, 0);
        checkOutput("mr_ack", ack_o, 0);
        checkOutput("mr_data", data_o, 0);
        checkOutput("mr_cnt", xfer_cnt_o, 0);
        expQ.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        waitCycles(10);
        checkOutput("mr_no_word", valid_o, 0);
        checkOutput("mr_busy", busy_o, 0);

        // Counter wrap: 17 transfers on a 4-bit counter
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) sendAndWait(DATA_W'($urandom));
        waitCycles(1);
        checkOutput("wrap_16", xfer_cnt_o, 0);
        sendAndWait(8'hE1);
        waitCycles(1);
        checkOutput("wrap_17", xfer_cnt_o, 1);

        // Clear coincident with a completion edge: clear wins
        applyStimulus(8'h9B);
        waitForValid();
        clr_i = 1'b1;
        waitCycles(1);
        clr_i = 1'b0;
        checkOutput("clr_win_valid", valid_o, 0);
        checkOutput("clr_win_cnt", xfer_cnt_o, 0);

        waitCycles(4);
        checkOutput("sb_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Absolute time guard so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_xd_hs_rx

// File: doc/xd_hs_rx.md
Name: xd_hs_rx

Overview:
- Destination-domain end of a two-phase (toggle) req/ack bundled-data crossing.
- A source-domain transmitter toggles req_i after driving data_i. This block:
  - synchronises req_i;
  - captures data_i;
  - presents the word on a valid/ready interface in its own clock domain;
  - toggles ack_o back to the transmitter once the word is consumed.
- Sits at the pixel-clock side of multi-bit control paths (e.g. cube rotation/colour settings from the system clock) where a single-pulse crossing is insufficient.

Parameters:
- DATA_W, 8, width of data_i/data_o.
- SYNC_STAGES, 2, flops in the req_i synchroniser; legal range 2..4.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk_i  input  1  destination-domain clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  1  request toggle from the source domain (asynchronous to clk_i).
- data_i  input  DATA_W  bundled data from the source domain; stable from before a req_i toggle until the matching ack_o toggle is seen by the source.
- ack_o  output  1  acknowledge toggle back to the source domain (registered, glitch-free).
- valid_o  output  1  data_o holds an unconsumed word.
- data_o  output  DATA_W  captured word.
- ready_i  input  1  downstream accepts data_o.
- busy_o  output  1  request pending or word held (req_sync != ack_o, or valid_o).
- overrun_o  output  1  sticky protocol-error flag.
- clr_i  input  1  synchronous clear of overrun_o and xfer_cnt_o.
- xfer_cnt_o  output  CNT_W  completed-transfer count.

Behaviour:
- Reset (rst_ni low, asynchronous): all of the following are 0 and the FSM is in IDLE:
  - synchroniser flops, req_sync_q, ack_o, valid_o, data_o, overrun_o, xfer_cnt_o.
- Reset deassertion is synchronised externally; the block does not re-synchronise rst_ni.
- Synchroniser: req_sync = last stage of the SYNC_STAGES chain sampling req_i.
- Pending condition: pend = req_sync ^ ack_o.
- FSM states IDLE, HOLD.
- IDLE, on pend=1 at edge E:
  - data_o <= data_i; valid_o <= 1; go HOLD.
  - Latency: req_i toggle first sampled at edge E0 -> valid_o high after edge E(SYNC_STAGES); 2 stages -> 3 edges.
  - data_i is safe to sample because req_i has been stable for SYNC_STAGES cycles (bundled-data constraint; the source must settle data_i before toggling req_i).
- HOLD, on valid_o & ready_i at edge E:
  - transfer completes; valid_o <= 0; ack_o <= ~ack_o; xfer_cnt_o += 1 (wraps modulo 2^CNT_W); go IDLE.
  - data_o retains its last value after the transfer.
- HOLD with ready_i=0: valid_o and data_o are held unchanged indefinitely.
- Back-to-back transfers:
  - After the ack toggle, pend=0 until the source toggles req_i again.
  - The next valid_o is therefore no earlier than SYNC_STAGES+1 edges after that toggle reaches the synchroniser.
- ready_i already high when valid_o rises: the transfer completes on the next edge (valid_o high exactly 1 cycle).
- Overrun, detected in HOLD only: req_sync != req_sync_q means the source toggled again before ack.
  - overrun_o <= 1 (sticky).
  - The held word is unaffected.
  - The extra toggle is absorbed: pend may read 0 after ack; no additional word is generated.
- clr_i:
  - clears overrun_o and xfer_cnt_o on the next edge.
  - If clr_i coincides with an overrun detection, the set wins.
  - If clr_i coincides with a transfer completion, the counter reads 0 (clear wins over increment).
- Reset mid-operation: the held word is dropped and ack_o returns to 0. The source must be reset concurrently with req=0. If req_i is still 1 after reset, pend becomes 1 and one word is captured (documented, not an error).
- busy_o is combinational from registers only.

Decomposition:
- Package xd_pkg:
  - typedef enum logic {IDLE, HOLD} xd_rx_state_t;
  - localparam XD_SYNC_STAGES_DEF = 2.
- Sub-module xd_sync: SYNC_STAGES-deep single-bit synchroniser, async active-low reset to 0, async-register attributes on its flops. Reusable by the matching transmitter for the ack path.

Test Plan:
- Single transfer, DATA_W=8, ready_i=1: data_i=8'hA5, toggle req_i 0->1 -> valid_o high for 1 cycle, starting 3 edges after sampling; data_o=8'hA5; ack_o 0->1; xfer_cnt_o=1.
- Backpressure: ready_i=0 for 20 cycles after valid_o -> valid_o and data_o=8'h3C stable for all 20; ack_o unchanged; ready_i=1 -> ack_o toggles on that edge, valid_o drops.
- Four back-to-back transfers 8'h01..8'h04 (source toggles req_i only after seeing ack_o) -> four words delivered in order; ack_o toggles 4 times, ending at 0; xfer_cnt_o=4; overrun_o=0.
- Overrun: toggle req_i twice while ready_i=0 -> overrun_o=1 after sync latency; data_o keeps the first word; after ready_i, exactly one transfer; clr_i -> overrun_o=0, xfer_cnt_o=0.
- Reset mid-HOLD: assert rst_ni low asynchronously (between edges) with valid_o=1 -> valid_o, ack_o, data_o, xfer_cnt_o all 0 immediately; with req_i held 0, no word appears after release.
- Counter wrap with CNT_W=4: 17 transfers -> xfer_cnt_o=1; clr_i on the completion edge -> 0.
